// File: rtl/alu_mul_seq_if.sv
// Bus between the core, the multiply sequencer and the 8-bit ALU.
// The mul_signed request bit exists only when ALU_MUL_SIGNED_EN is defined.
interface alu_mul_seq_if #(parameter int WIDTH = 8);
    logic               start;
    logic [WIDTH-1:0]   op_a;
    logic [WIDTH-1:0]   op_b;
`ifdef ALU_MUL_SIGNED_EN
    logic               mul_signed;
`endif
    logic               busy;
    logic               stall;
    logic               done;
    logic [2*WIDTH-1:0] product;

    logic [WIDTH-1:0]   core_a;
    logic [WIDTH-1:0]   core_b;
    logic               core_cin;
    logic               core_is_shift;
    logic               core_update_zc;
    logic [1:0]         core_scode;
    logic [2:0]         core_acode;

    logic [WIDTH-1:0]   alu_a;
    logic [WIDTH-1:0]   alu_b;
    logic               alu_cin;
    logic               alu_is_shift;
    logic               alu_update_zc;
    logic [1:0]         alu_scode;
    logic [2:0]         alu_acode;
    logic [WIDTH-1:0]   alu_r;
    logic               alu_carry;

    modport slave (
        input  start, op_a, op_b,
`ifdef ALU_MUL_SIGNED_EN
        input  mul_signed,
`endif
        output busy, stall, done, product,
        input  core_a, core_b, core_cin, core_is_shift, core_update_zc,
        input  core_scode, core_acode,
        output alu_a, alu_b, alu_cin, alu_is_shift, alu_update_zc,
        output alu_scode, alu_acode,
        input  alu_r, alu_carry
    );

    modport master (
        output start, op_a, op_b,
`ifdef ALU_MUL_SIGNED_EN
        output mul_signed,
`endif
        input  busy, stall, done, product,
        output core_a, core_b, core_cin, core_is_shift, core_update_zc,
        output core_scode, core_acode,
        input  alu_a, alu_b, alu_cin, alu_is_shift, alu_update_zc,
        input  alu_scode, alu_acode,
        output alu_r, alu_carry
    );
endinterface

// File: rtl/alu_mul_seq.sv
// Shift-add multiply sequencer that borrows the core's ALU for WIDTH cycles.
// Optional signed multiply is enabled by defining ALU_MUL_SIGNED_EN.
module alu_mul_seq #(
    parameter int WIDTH = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    alu_mul_seq_if.slave  bus
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;
    logic [WIDTH-1:0]     mcand_q, mcand_d;
    logic [CW-1:0]        count_q, count_d;
    logic [2*WIDTH-1:0]   product_q, product_d;
    logic                 neg_q, neg_d;

    logic [WIDTH-1:0]     a_mag, b_mag;
    logic                 neg_in;
    logic [2*WIDTH:0]     acc;
    logic [2*WIDTH-1:0]   shifted;

`ifdef ALU_MUL_SIGNED_EN
    // The magnitude of the most negative operand wraps to itself, which is the correct unsigned value.
    always_comb begin
        a_mag  = (bus.mul_signed && bus.op_a[WIDTH-1]) ? (~bus.op_a + 1'b1) : bus.op_a;
        b_mag  = (bus.mul_signed && bus.op_b[WIDTH-1]) ? (~bus.op_b + 1'b1) : bus.op_b;
        neg_in = bus.mul_signed & (bus.op_a[WIDTH-1] ^ bus.op_b[WIDTH-1]);
    end
`else
    always_comb begin
        a_mag  = bus.op_a;
        b_mag  = bus.op_b;
        neg_in = 1'b0;
    end
`endif

    assign acc     = {bus.alu_carry, bus.alu_r, lo_q};
    assign shifted = acc[2*WIDTH:1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            hi_q      <= '0;
            lo_q      <= '0;
            mcand_q   <= '0;
            count_q   <= '0;
            product_q <= '0;
            neg_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            mcand_q   <= mcand_d;
            count_q   <= count_d;
            product_q <= product_d;
            neg_q     <= neg_d;
        end
    end

    always_comb begin
        state_d           = state_q;
        hi_d              = hi_q;
        lo_d              = lo_q;
        mcand_d           = mcand_q;
        count_d           = count_q;
        product_d         = product_q;
        neg_d             = neg_q;

        bus.alu_a         = bus.core_a;
        bus.alu_b         = bus.core_b;
        bus.alu_cin       = bus.core_cin;
        bus.alu_is_shift  = bus.core_is_shift;
        bus.alu_update_zc = bus.core_update_zc;
        bus.alu_scode     = bus.core_scode;
        bus.alu_acode     = bus.core_acode;

        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = S_RUN;
                    hi_d    = '0;
                    lo_d    = b_mag;
                    mcand_d = a_mag;
                    count_d = '0;
                    neg_d   = neg_in;
                end
            end
            S_RUN: begin
                bus.alu_a         = hi_q;
                bus.alu_b         = lo_q[0] ? mcand_q : '0;
                bus.alu_cin       = 1'b0;
                bus.alu_is_shift  = 1'b0;
                bus.alu_update_zc = 1'b1;
                bus.alu_scode     = 2'b00;
                bus.alu_acode     = 3'b000;
                {hi_d, lo_d}      = shifted;
                count_d           = count_q + 1'b1;
                // Product is committed from the final shift so it is valid in the DONE cycle.
                if (count_q == CW'(WIDTH - 1)) begin
                    state_d   = S_DONE;
                    product_d = neg_q ? (~shifted + 1'b1) : shifted;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.busy    = (state_q != S_IDLE);
    assign bus.stall   = (state_q == S_RUN);
    assign bus.done    = (state_q == S_DONE);
    assign bus.product = product_q;

endmodule
